char_rom_sequencer: RTL and testbench

- Sequences the 4-glyph character ROM (F, Q, H, X; 16 rows x 8 bits; address = {glyph[1:0], row[3:0]}; output forced to 0 when char_enable is low) for the VGA path.
- Maps live hcount/vcount to a ROM address and serialises each returned row into a per-pixel foreground bit.
- Holds a 4-slot text line written from the PS/2 side and commits it only at frame boundaries, so no tearing.
- Adds a blinking cursor; forwards blank/sync delayed to match the pixel pipeline.

---
 rtl/char_pkg.sv | 24 ++
 rtl/text_slot_buffer.sv | 61 ++++++
 rtl/char_rom_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_char_rom_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_pkg.sv
// rtl/char_pkg.sv - shared glyph codes, text geometry and sequencer state encoding
//
// Purpose : constants and types shared by the character ROM sequencer and its
//           text slot buffer.
// Ports   : none (package).
package char_pkg;

   localparam logic [1:0] GLYPH_F = 2'd0;
   localparam logic [1:0] GLYPH_Q = 2'd1;
   localparam logic [1:0] GLYPH_H = 2'd2;
   localparam logic [1:0] GLYPH_X = 2'd3;

   localparam int CHAR_W = 8;
   localparam int CHAR_H = 16;
   localparam int NSLOTS = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ROWS   = 2'd1,
      S_WAITV  = 2'd2,
      S_COMMIT = 2'd3
   } seq_state_e;

endpackage

// File: rtl/text_slot_buffer.sv
// rtl/text_slot_buffer.sv - pending/active text slots with frame-boundary commit
//
// Purpose : holds the 4-slot text line. Writes land in the pending copy; the
//           active copy (what the pixel path renders) only changes on i_commit.
// Ports   : i_clk, i_rst_n          clock, async active-low reset
//           i_wr_en/slot/code/valid  slot write from the PS/2 side
//           i_commit                 copy pending -> active this cycle
//           o_act_code/o_act_valid   active slots for rendering
//           o_dirty                  pending differs from active (write since commit)
module text_slot_buffer
   import char_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_wr_en,
   input  logic [1:0]             i_wr_slot,
   input  logic [1:0]             i_wr_code,
   input  logic                   i_wr_valid,
   input  logic                   i_commit,
   output logic [NSLOTS-1:0][1:0] o_act_code,
   output logic [NSLOTS-1:0]      o_act_valid,
   output logic                   o_dirty
);

   logic [NSLOTS-1:0][1:0] r_pend_code;
   logic [NSLOTS-1:0]      r_pend_valid;
   logic [NSLOTS-1:0][1:0] r_act_code;
   logic [NSLOTS-1:0]      r_act_valid;
   logic                   r_dirty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pend_code  <= '0;
         r_pend_valid <= '0;
         r_act_code   <= '0;
         r_act_valid  <= '0;
         r_dirty      <= 1'b0;
      end else begin
         // Commit copies the pending state as it stood before this edge, so a
         // write landing in the commit cycle stays pending for the next frame.
         if (i_commit) begin
            r_act_code  <= r_pend_code;
            r_act_valid <= r_pend_valid;
         end
         if (i_wr_en) begin
            r_pend_code[i_wr_slot]  <= i_wr_code;
            r_pend_valid[i_wr_slot] <= i_wr_valid;
         end
         if (i_wr_en) begin
            r_dirty <= 1'b1;
         end else if (i_commit) begin
            r_dirty <= 1'b0;
         end
      end
   end

   assign o_act_code  = r_act_code;
   assign o_act_valid = r_act_valid;
   assign o_dirty     = r_dirty;

endmodule

// File: rtl/char_rom_sequencer.sv
// rtl/char_rom_sequencer.sv - VGA text box sequencer driving the 4-glyph character ROM
//
// Purpose : maps hcount/vcount into ROM addresses for a 4-glyph text box,
//           serialises ROM rows into pixel_on, blinks a cursor and delays
//           blank/sync to match the 2-cycle pixel pipeline.
// Ports   : i_clk, i_rst_n                      pixel clock, async active-low reset
//           i_hcount, i_vcount                  live scan position
//           i_video_on_in, i_hsync_in, i_vsync_in  timing flags aligned with scan
//           i_wr_en/slot/code/valid             text slot write
//           i_cursor_slot, i_cursor_en          blinking cursor control
//           o_rom_char_enable, o_rom_address    ROM request
//           i_rom_data                          ROM row (combinational ROM)
//           o_pixel_on                          foreground bit
//           o_video_on_out, o_hsync_out, o_vsync_out  timing delayed 2 cycles
module char_rom_sequencer
   import char_pkg::*;
#(
   parameter logic [9:0]  X0           = 10'd288,
   parameter logic [9:0]  Y0           = 10'd232,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [9:0] i_hcount,
   input  logic [9:0] i_vcount,
   input  logic       i_video_on_in,
   input  logic       i_hsync_in,
   input  logic       i_vsync_in,
   input  logic       i_wr_en,
   input  logic [1:0] i_wr_slot,
   input  logic [1:0] i_wr_code,
   input  logic       i_wr_valid,
   input  logic [1:0] i_cursor_slot,
   input  logic       i_cursor_en,
   output logic       o_rom_char_enable,
   output logic [5:0] o_rom_address,
   input  logic [7:0] i_rom_data,
   output logic       o_pixel_on,
   output logic       o_video_on_out,
   output logic       o_hsync_out,
   output logic       o_vsync_out
);

   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
   localparam logic [9:0] BOX_W      = 10'(CHAR_W * NSLOTS);
   localparam logic [9:0] BOX_H      = 10'(CHAR_H);

   // box geometry
   logic [4:0] w_dx;
   logic [3:0] w_row;
   logic [1:0] w_slot;
   logic [2:0] w_col;
   logic       w_in_box;

   // slot buffer
   logic [NSLOTS-1:0][1:0] w_act_code;
   logic [NSLOTS-1:0]      w_act_valid;
   logic                   w_dirty;
   logic                   w_commit;

   // frame sequencing and blink
   seq_state_e r_state;
   seq_state_e w_next_state;
   logic       w_vsync_fall;
   logic [7:0] r_blink_cnt;
   logic       r_blink_phase;

   // pipeline stage 0
   logic [5:0] r_rom_address;
   logic       r_rom_char_enable;
   logic [2:0] r_col_d1;
   logic       r_cursor_hit_d1;
   logic       r_video_d1;
   logic       r_hsync_d1;
   logic       r_vsync_d1;

   // pipeline stage 1
   logic       r_pixel_on;
   logic       r_video_d2;
   logic       r_hsync_d2;
   logic       r_vsync_d2;

   // Only the low bits of the offsets are needed; outside the box they wrap
   // harmlessly because in_box gates everything visible.
   assign w_dx     = 5'(i_hcount - X0);
   assign w_row    = 4'(i_vcount - Y0);
   assign w_slot   = w_dx[4:3];
   assign w_col    = w_dx[2:0];
   assign w_in_box = (i_hcount >= X0) && (i_hcount < X0 + BOX_W) &&
                     (i_vcount >= Y0) && (i_vcount < Y0 + BOX_H) &&
                     i_video_on_in;

   // r_vsync_d1 doubles as the previous-cycle vsync for edge detection.
   assign w_vsync_fall = r_vsync_d1 & ~i_vsync_in;

   text_slot_buffer u_slots (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_wr_en     (i_wr_en),
      .i_wr_slot   (i_wr_slot),
      .i_wr_code   (i_wr_code),
      .i_wr_valid  (i_wr_valid),
      .i_commit    (w_commit),
      .o_act_code  (w_act_code),
      .o_act_valid (w_act_valid),
      .o_dirty     (w_dirty)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Commit waits until the box rows are finished and vsync starts, so the
   // active text never changes while the box is on screen.
   always_comb begin
      w_next_state = r_state;
      w_commit     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if ((i_vcount == Y0) && (i_hcount == 10'd0)) begin
               w_next_state = S_ROWS;
            end
         end
         S_ROWS: begin
            if (i_vcount == Y0 + BOX_H) begin
               w_next_state = S_WAITV;
            end
         end
         S_WAITV: begin
            if (w_vsync_fall) begin
               w_next_state = w_dirty ? S_COMMIT : S_IDLE;
            end
         end
         S_COMMIT: begin
            w_commit     = 1'b1;
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_blink_cnt   <= 8'd0;
         r_blink_phase <= 1'b0;
      end else if (w_vsync_fall) begin
         if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt   <= 8'd0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rom_address     <= 6'd0;
         r_rom_char_enable <= 1'b0;
         r_col_d1          <= 3'd0;
         r_cursor_hit_d1   <= 1'b0;
         r_video_d1        <= 1'b0;
         r_hsync_d1        <= 1'b1;
         r_vsync_d1        <= 1'b1;
      end else begin
         r_rom_address     <= {w_act_code[w_slot], w_row};
         r_rom_char_enable <= w_in_box && w_act_valid[w_slot];
         r_col_d1          <= w_col;
         r_cursor_hit_d1   <= i_cursor_en && r_blink_phase && w_in_box &&
                              (w_slot == i_cursor_slot);
         r_video_d1        <= i_video_on_in;
         r_hsync_d1        <= i_hsync_in;
         r_vsync_d1        <= i_vsync_in;
      end
   end

   // Disabled ROM returns 0, so blank slots render background and a cursor on
   // a blank slot becomes a solid block.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pixel_on <= 1'b0;
         r_video_d2 <= 1'b0;
         r_hsync_d2 <= 1'b1;
         r_vsync_d2 <= 1'b1;
      end else begin
         r_pixel_on <= (i_rom_data[3'd7 - r_col_d1] & r_video_d1) ^ r_cursor_hit_d1;
         r_video_d2 <= r_video_d1;
         r_hsync_d2 <= r_hsync_d1;
         r_vsync_d2 <= r_vsync_d1;
      end
   end

   assign o_rom_address     = r_rom_address;
   assign o_rom_char_enable = r_rom_char_enable;
   assign o_pixel_on        = r_pixel_on;
   assign o_video_on_out    = r_video_d2;
   assign o_hsync_out       = r_hsync_d2;
   assign o_vsync_out       = r_vsync_d2;

endmodule

// File: tb/tb_char_rom_sequencer.sv
// tb/tb_char_rom_sequencer.sv - randomized self-checking bench for char_rom_sequencer
module tb_char_rom_sequencer;
   import char_pkg::*;

   localparam logic [9:0] X0    = 10'd8;
   localparam logic [9:0] Y0    = 10'd4;
   localparam int         BLINK = 2;
   localparam int H_TOT = 48, V_TOT = 26, H_VIS = 44, V_VIS = 22;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] hcount, vcount;
   logic       video_on, hsync, vsync;
   logic       wr_en, wr_valid, cursor_en;
   logic [1:0] wr_slot, wr_code, cursor_slot;
   logic       rom_char_enable;
   logic [5:0] rom_address;
   logic [7:0] rom_data;
   logic       pixel_on, video_on_out, hsync_out, vsync_out;

   always #5 clk = ~clk;

   char_rom_sequencer #(.X0(X0), .Y0(Y0), .BLINK_FRAMES(BLINK)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_hcount(hcount), .i_vcount(vcount),
      .i_video_on_in(video_on), .i_hsync_in(hsync), .i_vsync_in(vsync),
      .i_wr_en(wr_en), .i_wr_slot(wr_slot), .i_wr_code(wr_code), .i_wr_valid(wr_valid),
      .i_cursor_slot(cursor_slot), .i_cursor_en(cursor_en),
      .o_rom_char_enable(rom_char_enable), .o_rom_address(rom_address),
      .i_rom_data(rom_data), .o_pixel_on(pixel_on), .o_video_on_out(video_on_out),
      .o_hsync_out(hsync_out), .o_vsync_out(vsync_out)
   );

   function automatic logic [7:0] font_row(input logic [1:0] g, input int r);
      logic [7:0] d;
      d = 8'h00;
      if (g == GLYPH_F) begin
         if (r == 2 || r == 3 || r == 7) d = 8'hFF;
         else if (r >= 2 && r <= 13)     d = 8'hC0;
      end else if (g == GLYPH_Q) begin
         if (r == 0)       d = 8'h18;
         else if (r == 15) d = 8'h07;
         else              d = 8'h66;
      end else if (g == GLYPH_H) begin
         d = (r == 7 || r == 8) ? 8'hFF : 8'hC3;
      end else begin
         d = (r % 2 == 0) ? 8'h81 : 8'h42;
      end
      return d;
   endfunction

   assign rom_data = rom_char_enable ? font_row(rom_address[5:4], int'(rom_address[3:0])) : 8'h00;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
   endtask

   // reference model
   logic [1:0] m_pend_code [4];
   logic [1:0] m_act_code  [4];
   bit         m_pend_valid[4];
   bit         m_act_valid [4];
   bit         m_dirty, m_commit_next, m_box_started, m_box_done, m_vs_prev;
   int         m_falls;
   logic [3:0] exp_q[$];
   int         pos_q[$];

   int  h, v, fr;
   bit  rand_on, arm_cw, reset_req;
   logic [4:0] wq[$];

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_pend_code[i] = 2'd0; m_act_code[i] = 2'd0;
         m_pend_valid[i] = 1'b0; m_act_valid[i] = 1'b0;
      end
      m_dirty = 0; m_commit_next = 0; m_box_started = 0; m_box_done = 0;
      m_vs_prev = 1; m_falls = 0;
      exp_q.delete(); exp_q.push_back(4'b0011);
      pos_q.delete(); pos_q.push_back(-1);
   endtask

   task automatic model_expect(output logic [3:0] e, output logic [5:0] ea, output logic ece);
      int dx, s, c, r;
      bit inb, g, cur;
      logic [7:0] rowbits;
      dx = (int'(hcount) - int'(X0) + 1024) % 1024;
      s  = (dx / 8) % 4;
      c  = dx % 8;
      r  = ((int'(vcount) - int'(Y0) + 1024) % 1024) % 16;
      inb = (hcount >= X0) && (int'(hcount) < int'(X0) + 32) &&
            (vcount >= Y0) && (int'(vcount) < int'(Y0) + 16) && video_on;
      rowbits = font_row(m_act_code[s], r);
      g   = inb && m_act_valid[s] && rowbits[7 - c];
      cur = cursor_en && ((m_falls / BLINK) % 2 == 1) && inb && (s == int'(cursor_slot));
      e   = {g ^ cur, video_on, hsync, vsync};
      ea  = {m_act_code[s], 4'(r)};
      ece = inb && m_act_valid[s];
   endtask

   // Frame-level text model: a frame whose box rows were fully scanned commits
   // pending text one cycle after the vsync falling edge, if anything was written.
   task automatic model_edge();
      bit fall, dold;
      fall = m_vs_prev && !vsync;
      dold = m_dirty;
      if (m_commit_next) begin
         for (int i = 0; i < 4; i++) begin
            m_act_code[i] = m_pend_code[i]; m_act_valid[i] = m_pend_valid[i];
         end
         m_dirty = 0;
      end
      m_commit_next = 0;
      if (!m_box_started && int'(vcount) == int'(Y0) && hcount == 0) m_box_started = 1;
      else if (m_box_started && !m_box_done && int'(vcount) == int'(Y0) + 16) m_box_done = 1;
      if (fall) begin
         m_falls++;
         if (m_box_done) begin
            m_commit_next = dold; m_box_started = 0; m_box_done = 0;
         end
      end
      if (wr_en) begin
         m_pend_code[wr_slot] = wr_code; m_pend_valid[wr_slot] = wr_valid; m_dirty = 1;
      end
      m_vs_prev = vsync;
   endtask

   task automatic drive_timing();
      hcount   = 10'(h);
      vcount   = 10'(v);
      video_on = (h < H_VIS) && (v < V_VIS);
      hsync    = !(h >= 44 && h < 46);
      vsync    = !(v >= 23 && v < 25);
   endtask

   task automatic drive_writes();
      logic [4:0] w;
      wr_en = 1'b0;
      if (arm_cw && m_commit_next) begin
         wr_en = 1'b1; wr_slot = 2'd3; wr_code = GLYPH_Q; wr_valid = 1'b1; arm_cw = 0;
      end else if (wq.size() > 0) begin
         w = wq.pop_front();
         wr_en = 1'b1; {wr_valid, wr_code, wr_slot} = w;
      end else if (rand_on && $urandom_range(39) == 0) begin
         wr_en = 1'b1; wr_slot = 2'($urandom_range(3)); wr_code = 2'($urandom_range(3));
         wr_valid = 1'($urandom_range(1));
      end
   endtask

   function automatic bit in_rows(input int yy);
      return yy >= int'(Y0) && yy < int'(Y0) + 16;
   endfunction

   function automatic bit in_slot(input int xx, input int s);
      return xx >= int'(X0) + 8 * s && xx < int'(X0) + 8 * s + 8;
   endfunction

   task automatic directed(input int pv, input int ph, input int ppv, input int pph);
      logic [7:0] qrow;
      qrow = 8'h18;
      if (fr == 0 && pv == Y0 + 7 && ph == X0) chk("frameN_unchanged", rom_char_enable, 0);
      if (fr == 1 && pv == Y0 + 7 && ph == X0) chk("addr_f_r7", rom_address, 6'h07);
      if (fr == 1 && pv == Y0 + 7 && ph == X0 + 8) chk("addr_q_r7", rom_address, 6'h17);
      if (fr == 1 && ppv == Y0 + 7 && in_slot(pph, 0)) chk("f_r7_px", pixel_on, 1);
      if (fr == 1 && ppv == Y0 && in_slot(pph, 1))
         chk("q_r0_px", pixel_on, qrow[7 - (pph - X0 - 8)]);
      if (fr == 2 && in_rows(pv) && in_slot(ph, 2)) chk("blank_ce", rom_char_enable, 0);
      if (fr == 2 && in_rows(ppv) && in_slot(pph, 2)) chk("blank_px", pixel_on, 0);
      if (fr == 2 && pv == Y0 + 3 && (ph == X0 - 1 || ph == X0 + 32))
         chk("edge_ce", rom_char_enable, 0);
      if (fr >= 2 && fr <= 5 && ppv == Y0 && in_slot(pph, 0))
         chk("cursor_f", pixel_on, ((fr / 2) % 2 == 1) ? 1 : 0);
      if (fr == 6 && in_rows(ppv) && in_slot(pph, 2)) chk("cursor_blank", pixel_on, 1);
      if (fr == 8 && pv == Y0 + 2 && ph == X0 + 24) chk("commit_wr_absent", rom_address, 6'h32);
      if (fr == 9 && pv == Y0 + 2 && ph == X0 + 24) chk("commit_wr_present", rom_address, 6'h12);
      if (fr == 11 && in_rows(pv) && ph >= X0 && ph < X0 + 32)
         chk("post_reset_blank", rom_char_enable, 0);
      if (fr == 12 && pv == Y0 + 2 && ph == X0 + 8) chk("post_reset_commit", rom_address, 6'h22);
   endtask

   task automatic step();
      logic [3:0] e, ep;
      logic [5:0] ea;
      logic       ece;
      int pv, ph, pos, ppv, pph;
      model_expect(e, ea, ece);
      exp_q.push_back(e);
      pos_q.push_back(v * 1024 + h);
      pv = v; ph = h;
      @(posedge clk);
      model_edge();
      #1;
      ep  = exp_q.pop_front();
      pos = pos_q.pop_front();
      ppv = (pos < 0) ? -1 : pos / 1024;
      pph = (pos < 0) ? -1 : pos % 1024;
      chk("pipe", {pixel_on, video_on_out, hsync_out, vsync_out}, ep);
      chk("rom_ce", rom_char_enable, ece);
      chk("rom_addr", rom_address, ea);
      directed(pv, ph, ppv, pph);
      h++;
      if (h == H_TOT) begin h = 0; v = (v + 1) % V_TOT; end
      drive_timing();
      drive_writes();
   endtask

   task automatic mid_reset();
      rst_n = 1'b0;
      #1;
      chk("arst_pixel", pixel_on, 0);
      chk("arst_hsync", hsync_out, 1);
      chk("arst_vsync", vsync_out, 1);
      chk("arst_ce", rom_char_enable, 0);
      #1;
      rst_n = 1'b1;
      model_reset();
      reset_req = 0;
      wq.push_back({1'b1, GLYPH_H, 2'd1});
   endtask

   task automatic run_frame();
      for (int n = 0; n < H_TOT * V_TOT; n++) begin
         if (reset_req && v == Y0 + 5 && h == X0 + 10) mid_reset();
         step();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      h = 0; v = 0; fr = 0;
      rand_on = 0; arm_cw = 0; reset_req = 0;
      wr_en = 0; wr_slot = 0; wr_code = 0; wr_valid = 0;
      cursor_en = 0; cursor_slot = 0;
      drive_timing();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pixel", pixel_on, 0);
      chk("rst_video", video_on_out, 0);
      chk("rst_hsync", hsync_out, 1);
      chk("rst_vsync", vsync_out, 1);
      chk("rst_addr", rom_address, 0);
      chk("rst_ce", rom_char_enable, 0);
      rst_n = 1'b1;
      model_reset();

      for (int f = 0; f < 16; f++) begin
         fr = f;
         case (f)
            0: begin
               wq.push_back({1'b1, GLYPH_F, 2'd0});
               wq.push_back({1'b1, GLYPH_Q, 2'd1});
               wq.push_back({1'b1, GLYPH_H, 2'd2});
               wq.push_back({1'b1, GLYPH_X, 2'd3});
            end
            1: wq.push_back({1'b0, GLYPH_H, 2'd2});
            2: begin cursor_en = 1; cursor_slot = 2'd0; end
            6: cursor_slot = 2'd2;
            7: begin
               cursor_en = 0;
               wq.push_back({1'b1, GLYPH_X, 2'd0});
               arm_cw = 1;
            end
            8: chk("dirty_after_commit", dut.u_slots.o_dirty, 1);
            10: reset_req = 1;
            12: rand_on = 1;
            default: ;
         endcase
         if (rand_on) begin
            cursor_en   = 1'($urandom_range(1));
            cursor_slot = 2'($urandom_range(3));
         end
         drive_writes();
         run_frame();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
